// File: rtl/partial_sat_if.sv
// Clause-evaluator bus: clause word in, partial-sat flag and
// registered BCP status out.
interface partial_sat_if #(
  parameter int var_num = 8
);
  localparam int idx_w = $clog2(var_num);
  localparam int cnt_w = $clog2(var_num + 1);

  logic [var_num-1:0] assignment;
  logic [var_num-1:0] clause_type;
  logic [var_num-1:0] clause_mask;
  logic [var_num-1:0] assigned;
  logic               in_valid;
  logic               part_sat;
  logic               out_valid;
  logic               sat_q;
  logic               conflict_q;
  logic               unit_q;
  logic [idx_w-1:0]   unit_idx;
  logic               unit_val;
  logic [cnt_w-1:0]   free_cnt;

  modport master (
    output assignment,
    output clause_type,
    output clause_mask,
    output assigned,
    output in_valid,
    input  part_sat,
    input  out_valid,
    input  sat_q,
    input  conflict_q,
    input  unit_q,
    input  unit_idx,
    input  unit_val,
    input  free_cnt
  );

  modport slave (
    input  assignment,
    input  clause_type,
    input  clause_mask,
    input  assigned,
    input  in_valid,
    output part_sat,
    output out_valid,
    output sat_q,
    output conflict_q,
    output unit_q,
    output unit_idx,
    output unit_val,
    output free_cnt
  );
endinterface

// File: rtl/partial_sat.sv
// BCP clause evaluator: combinational partial-sat flag plus a
// one-cycle registered satisfied/conflict/unit/free-count status.
module partial_sat #(
  parameter int var_num = 8
) (
  input logic          clk,
  input logic          rst_n,
  partial_sat_if.slave bus
);
  localparam int idx_w = $clog2(var_num);
  localparam int cnt_w = $clog2(var_num + 1);

  logic [var_num-1:0] lit;
  logic [var_num-1:0] alit;
  logic [var_num-1:0] free;
  logic               sat_n;
  logic               conflict_n;
  logic               unit_n;
  logic [cnt_w-1:0]   cnt_n;
  logic [idx_w-1:0]   idx_n;
  logic               val_n;

  always_comb begin
    lit  = bus.clause_mask
         & ~(bus.assignment ^ bus.clause_type);
    alit = lit & bus.assigned;
    free = bus.clause_mask & ~bus.assigned;
  end

  assign bus.part_sat = |lit;

  always_comb begin
    cnt_n = '0;
    idx_n = '0;
    for (int i = 0; i < var_num; i++)
      cnt_n = cnt_n + cnt_w'(free[i]);
    // Scan downward so the lowest free index wins.
    for (int i = var_num - 1; i >= 0; i--)
      if (free[i]) idx_n = idx_w'(i);
    sat_n      = |alit;
    conflict_n = ~sat_n & (cnt_n == '0);
    unit_n     = ~sat_n & (cnt_n == cnt_w'(1));
    val_n      = unit_n & bus.clause_type[idx_n];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.out_valid  <= 1'b0;
      bus.sat_q      <= 1'b0;
      bus.conflict_q <= 1'b0;
      bus.unit_q     <= 1'b0;
      bus.unit_idx   <= '0;
      bus.unit_val   <= 1'b0;
      bus.free_cnt   <= '0;
    end else begin
      bus.out_valid <= bus.in_valid;
      if (bus.in_valid) begin
        bus.sat_q      <= sat_n;
        bus.conflict_q <= conflict_n;
        bus.unit_q     <= unit_n;
        bus.unit_idx   <= idx_n;
        bus.unit_val   <= val_n;
        bus.free_cnt   <= cnt_n;
      end
    end
  end
endmodule

// File: tb/tb_partial_sat.sv
// Directed bench for partial_sat with var_num = 8.
// Expected values are hand-computed per vector.
module tb_partial_sat;
  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;

  partial_sat_if #(.var_num(8)) bus ();

  partial_sat #(.var_num(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [7:0] a,
                       input logic [7:0] t,
                       input logic [7:0] m,
                       input logic [7:0] asg,
                       input logic       v);
    bus.assignment  = a;
    bus.clause_type = t;
    bus.clause_mask = m;
    bus.assigned    = asg;
    bus.in_valid    = v;
    #1;
  endtask

  task automatic chk_status(input string tag,
                            input logic ov,
                            input logic s,
                            input logic c,
                            input logic u,
                            input logic [2:0] ix,
                            input logic uv,
                            input logic [3:0] fc);
    chk({tag, ".out_valid"}, 32'(bus.out_valid), 32'(ov));
    chk({tag, ".sat_q"}, 32'(bus.sat_q), 32'(s));
    chk({tag, ".conflict_q"}, 32'(bus.conflict_q), 32'(c));
    chk({tag, ".unit_q"}, 32'(bus.unit_q), 32'(u));
    chk({tag, ".unit_idx"}, 32'(bus.unit_idx), 32'(ix));
    chk({tag, ".unit_val"}, 32'(bus.unit_val), 32'(uv));
    chk({tag, ".free_cnt"}, 32'(bus.free_cnt), 32'(fc));
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    drive(8'hAA, 8'hAA, 8'h00, 8'hFF, 1'b0);
    chk_status("reset", 0, 0, 0, 0, 3'd0, 0, 4'd0);

    tick();
    rst_n = 1'b1;

    // empty clause
    drive(8'hAA, 8'hAA, 8'h00, 8'hFF, 1'b1);
    chk("empty.part_sat", 32'(bus.part_sat), 32'd0);
    tick();
    chk_status("empty", 1, 0, 1, 0, 3'd0, 0, 4'd0);

    // full match
    drive(8'hAA, 8'hAA, 8'hFF, 8'hFF, 1'b1);
    chk("match.part_sat", 32'(bus.part_sat), 32'd1);
    tick();
    chk_status("match", 1, 1, 0, 0, 3'd0, 0, 4'd0);

    // full mismatch
    drive(8'hAA, 8'h55, 8'hFF, 8'hFF, 1'b1);
    chk("mism.part_sat", 32'(bus.part_sat), 32'd0);
    tick();
    chk_status("mism", 1, 0, 1, 0, 3'd0, 0, 4'd0);

    // upper-field mask, both polarities
    drive(8'hAA, 8'hAA, 8'hE0, 8'hFF, 1'b0);
    chk("upper1.part_sat", 32'(bus.part_sat), 32'd1);
    drive(8'hAA, 8'h4A, 8'hE0, 8'hFF, 1'b0);
    chk("upper0.part_sat", 32'(bus.part_sat), 32'd0);
    tick();
    chk("idle.out_valid", 32'(bus.out_valid), 32'd0);

    // unit on bit 6
    drive(8'hAA, 8'h4A, 8'hE0, 8'hBF, 1'b1);
    tick();
    chk_status("unit6", 1, 0, 0, 1, 3'd6, 1, 4'd1);

    // several free, none assigned: lowest free idx
    drive(8'h00, 8'h0F, 8'hF0, 8'h00, 1'b1);
    chk("free4.part_sat", 32'(bus.part_sat), 32'd1);
    tick();
    chk_status("free4", 1, 0, 0, 0, 3'd4, 0, 4'd4);

    // async reset mid-stream, no edge needed
    drive(8'hAA, 8'h4A, 8'hE0, 8'hBF, 1'b1);
    rst_n = 1'b0;
    #1;
    chk_status("arst", 0, 0, 0, 0, 3'd0, 0, 4'd0);
    chk("arst.part_sat0", 32'(bus.part_sat), 32'd0);
    drive(8'hAA, 8'hAA, 8'hE0, 8'hBF, 1'b1);
    chk("arst.part_sat1", 32'(bus.part_sat), 32'd1);
    tick();
    chk_status("inrst", 0, 0, 0, 0, 3'd0, 0, 4'd0);
    rst_n = 1'b1;

    // only top bit free, single pulse
    drive(8'h00, 8'hAA, 8'h80, 8'h00, 1'b1);
    tick();
    chk_status("top", 1, 0, 0, 1, 3'd7, 1, 4'd1);
    drive(8'h00, 8'h00, 8'hFF, 8'hFF, 1'b0);
    tick();
    chk_status("hold1", 0, 0, 0, 1, 3'd7, 1, 4'd1);
    tick();
    chk_status("hold2", 0, 0, 0, 1, 3'd7, 1, 4'd1);

    // back-to-back
    drive(8'hAA, 8'hAA, 8'hFF, 8'hFF, 1'b1);
    tick();
    chk_status("b2b1", 1, 1, 0, 0, 3'd0, 0, 4'd0);
    drive(8'hAA, 8'h55, 8'hFF, 8'hFF, 1'b1);
    tick();
    chk_status("b2b2", 1, 0, 1, 0, 3'd0, 0, 4'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end
endmodule
